// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine controller.
package vend_pkg;

  // FSM state codes, also exported on the state port for the display driver.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PAY    = 3'd1,
    ST_VEND   = 3'd2,
    ST_CHANGE = 3'd3,
    ST_REFUND = 3'd4
  } vend_state_e;

  // Coin values in 0.5-yuan units.
  localparam logic [1:0] HALF = 2'd1;
  localparam logic [1:0] ONE  = 2'd2;

endpackage

// File: rtl/vend_tick_cnt.sv
// Clearable tick counter with terminal-count flag.
// done is high on the tick that completes TERM counted ticks; the counter
// wraps to zero on that tick so back-to-back hold phases need no extra clear.
module vend_tick_cnt #(
  parameter int unsigned TERM = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic done
);

  localparam int unsigned W = (TERM > 1) ? $clog2(TERM) : 1;
  localparam logic [W-1:0] TC = W'(TERM - 1);

  logic [W-1:0] count;

  // done depends only on count and tick, never on clr, so clr may be derived
  // from logic that consumes done without forming a loop.
  assign done = tick && (count == TC);

  // Count tick pulses; clear on request or on reaching terminal count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (tick) begin
      count <= done ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending-machine controller: coin credit, vend/change/refund sequencing.
// Optional feature: define VEND_TIMEOUT_EN to auto-refund after
// TIMEOUT_TICKS ticks of inactivity in PAY.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE         = 5,
  parameter int unsigned MAX_BAL       = 40,
  parameter int unsigned HOLD_TICKS    = 4,
  parameter int unsigned TIMEOUT_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       coin_half,
  input  logic       coin_one,
  input  logic       buy,
  input  logic       cancel,
  output logic [7:0] balance,
  output logic [7:0] change,
  output logic       vend_out,
  output logic       change_out,
  output logic       reject,
  output logic       busy,
  output logic [2:0] state
);

  // Elaboration-time sanity check of the configuration.
  if (HOLD_TICKS < 1 || TIMEOUT_TICKS < 1 || MAX_BAL > 255) begin : g_bad_params
    $error("vend_ctrl: illegal parameter value");
  end

  vend_state_e state_q;
  vend_state_e state_n;
  logic [7:0]  bal_n;
  logic [7:0]  chg_n;
  logic        rej_n;

  logic [1:0]  coin_sum;
  logic        any_coin;
  logic [8:0]  sum9;
  logic        fits;
  logic        can_buy;
  logic        hold_clr;
  logic        hold_done;
  logic        timeout;

  assign coin_sum = (coin_half ? HALF : 2'd0) + (coin_one ? ONE : 2'd0);
  assign any_coin = coin_half || coin_one;
  assign sum9     = {1'b0, balance} + {7'd0, coin_sum};
  assign fits     = (sum9 <= 9'(MAX_BAL));
  assign can_buy  = (balance >= 8'(PRICE));

  // Hold counter only runs in the output-hold states.
  assign hold_clr = !((state_q == ST_VEND) || (state_q == ST_CHANGE) ||
                      (state_q == ST_REFUND));

  vend_tick_cnt #(.TERM(HOLD_TICKS)) u_hold (
    .clk  (clk),
    .rst  (rst),
    .clr  (hold_clr),
    .tick (tick),
    .done (hold_done)
  );

`ifdef VEND_TIMEOUT_EN
  logic to_clr;
  // An accepted coin in PAY is exactly the case where PAY holds and the
  // balance changes, so the clear is derived from next-state values.
  assign to_clr = (state_q != ST_PAY) ||
                  ((state_n == ST_PAY) && (bal_n != balance));

  vend_tick_cnt #(.TERM(TIMEOUT_TICKS)) u_timeout (
    .clk  (clk),
    .rst  (rst),
    .clr  (to_clr),
    .tick (tick),
    .done (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Next-state, credit and change computation.
  always_comb begin
    state_n = state_q;
    bal_n   = balance;
    chg_n   = change;
    rej_n   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_coin) begin
          if (fits) begin
            bal_n   = sum9[7:0];
            state_n = ST_PAY;
          end else begin
            rej_n = 1'b1;
          end
        end
      end
      ST_PAY: begin
        if (cancel || timeout) begin
          state_n = ST_REFUND;
          chg_n   = balance;
          bal_n   = '0;
          rej_n   = any_coin;
        end else if (buy && can_buy) begin
          state_n = ST_VEND;
          chg_n   = balance - 8'(PRICE);
          bal_n   = '0;
          rej_n   = any_coin;
        end else if (any_coin) begin
          if (fits) begin
            bal_n = sum9[7:0];
          end else begin
            rej_n = 1'b1;
          end
        end
      end
      ST_VEND: begin
        rej_n = any_coin;
        if (hold_done) begin
          state_n = (change != '0) ? ST_CHANGE : ST_IDLE;
        end
      end
      ST_CHANGE, ST_REFUND: begin
        rej_n = any_coin;
        if (hold_done) begin
          chg_n   = '0;
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        bal_n   = '0;
        chg_n   = '0;
        rej_n   = 1'b0;
      end
    endcase
  end

  // Register state and all outputs; outputs are decoded from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      balance    <= '0;
      change     <= '0;
      vend_out   <= 1'b0;
      change_out <= 1'b0;
      reject     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_n;
      balance    <= bal_n;
      change     <= chg_n;
      vend_out   <= (state_n == ST_VEND);
      change_out <= (state_n == ST_CHANGE) || (state_n == ST_REFUND);
      reject     <= rej_n;
      busy       <= (state_n == ST_VEND) || (state_n == ST_CHANGE) ||
                    (state_n == ST_REFUND);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed self-checking bench for vend_ctrl (default parameters).
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       coin_half = 1'b0;
  logic       coin_one = 1'b0;
  logic       buy = 1'b0;
  logic       cancel = 1'b0;
  logic [7:0] balance;
  logic [7:0] change;
  logic       vend_out;
  logic       change_out;
  logic       reject;
  logic       busy;
  logic [2:0] state;

  int n_assert = 0;
  int n_fail   = 0;

  vend_ctrl #(
    .PRICE         (5),
    .MAX_BAL       (40),
    .HOLD_TICKS    (4),
    .TIMEOUT_TICKS (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .coin_half  (coin_half),
    .coin_one   (coin_one),
    .buy        (buy),
    .cancel     (cancel),
    .balance    (balance),
    .change     (change),
    .vend_out   (vend_out),
    .change_out (change_out),
    .reject     (reject),
    .busy       (busy),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample #1 after the capturing edge.
  task automatic step(input logic h, input logic o, input logic b,
                      input logic c, input logic t);
    coin_half = h; coin_one = o; buy = b; cancel = c; tick = t;
    @(posedge clk); #1;
    coin_half = 1'b0; coin_one = 1'b0; buy = 1'b0; cancel = 1'b0; tick = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 0, 1);
      idle(1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(posedge clk); #1;
    do_reset();
    chk("rst_state", state, 0);
    chk("rst_balance", balance, 0);
    chk("rst_change", change, 0);
    chk("rst_vend_out", vend_out, 0);
    chk("rst_change_out", change_out, 0);
    chk("rst_reject", reject, 0);
    chk("rst_busy", busy, 0);

    // Exact payment: 2, 4, 5 then buy
    step(0, 1, 0, 0, 0);
    chk("p1_bal2", balance, 2);
    chk("p1_state_pay", state, 1);
    step(0, 1, 0, 0, 0);
    chk("p1_bal4", balance, 4);
    step(1, 0, 0, 0, 0);
    chk("p1_bal5", balance, 5);
    step(0, 0, 1, 0, 0);
    chk("p1_state_vend", state, 2);
    chk("p1_change0", change, 0);
    chk("p1_bal0", balance, 0);
    chk("p1_vend_out", vend_out, 1);
    chk("p1_busy", busy, 1);
    step(1, 0, 0, 0, 0);
    chk("p1_busy_reject", reject, 1);
    chk("p1_busy_bal", balance, 0);
    idle(1);
    chk("p1_reject_pulse", reject, 0);
    ticks(3);
    chk("p1_vend_3t", state, 2);
    chk("p1_vend_out_3t", vend_out, 1);
    ticks(1);
    chk("p1_idle", state, 0);
    chk("p1_vend_out_off", vend_out, 0);
    chk("p1_busy_off", busy, 0);

    // Overpayment: 6, buy -> change 1
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("p2_bal6", balance, 6);
    step(0, 0, 1, 0, 0);
    chk("p2_state_vend", state, 2);
    chk("p2_change1", change, 1);
    ticks(4);
    chk("p2_state_change", state, 3);
    chk("p2_change_out", change_out, 1);
    chk("p2_vend_out_off", vend_out, 0);
    chk("p2_change_still1", change, 1);
    ticks(3);
    chk("p2_change_3t", state, 3);
    ticks(1);
    chk("p2_idle", state, 0);
    chk("p2_change_clr", change, 0);
    chk("p2_change_out_off", change_out, 0);

    // Insufficient balance buy is ignored
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("p3_buy_low_state", state, 1);
    chk("p3_buy_low_bal", balance, 1);

    // Saturation at MAX_BAL
    do_reset();
    chk("p4_rst_bal", balance, 0);
    for (int i = 0; i < 19; i++) step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("p4_bal39", balance, 39);
    step(0, 1, 0, 0, 0);
    chk("p4_reject", reject, 1);
    chk("p4_bal_hold39", balance, 39);
    step(1, 0, 0, 0, 0);
    chk("p4_bal40", balance, 40);
    chk("p4_reject_clr", reject, 0);

    // Both coins at once, then cancel+buy+coin in one cycle
    do_reset();
    step(1, 1, 0, 0, 0);
    chk("p5_bal3", balance, 3);
    step(1, 1, 0, 0, 0);
    chk("p5_bal6", balance, 6);
    step(0, 1, 1, 1, 0);
    chk("p5_state_refund", state, 4);
    chk("p5_change6", change, 6);
    chk("p5_bal0", balance, 0);
    chk("p5_reject", reject, 1);
    chk("p5_change_out", change_out, 1);
    chk("p5_busy", busy, 1);
    ticks(4);
    chk("p5_idle", state, 0);
    chk("p5_change_clr", change, 0);

    // Reset during VEND
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("p6_vend", state, 2);
    ticks(1);
    do_reset();
    chk("p6_state", state, 0);
    chk("p6_vend_out", vend_out, 0);
    chk("p6_balance", balance, 0);
    chk("p6_change", change, 0);

    // Inactivity in PAY
    step(1, 1, 0, 0, 0);
    chk("p7_bal3", balance, 3);
    ticks(19);
    chk("p7_pay_19t", state, 1);
    ticks(1);
`ifdef VEND_TIMEOUT_EN
    chk("p7_state_refund", state, 4);
    chk("p7_change3", change, 3);
    chk("p7_bal0", balance, 0);
`else
    chk("p7_state_pay", state, 1);
    chk("p7_bal_kept", balance, 3);
    chk("p7_change0", change, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 Parameter PRICE, default 5: item price in 0.5-yuan units.
REQ-002 Parameter MAX_BAL, default 40: maximum balance in 0.5-yuan units (≤255).
REQ-003 Parameter HOLD_TICKS, default 4: tick count for the vend/change output hold (2 s at a 500 ms tick).
REQ-004 Parameter TIMEOUT_TICKS, default 20: inactivity ticks before auto-refund (only when the Configuration macro is defined).
REQ-005 Port clk, input, 1: single system clock.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port tick, input, 1: one-cycle strobe at 500 ms from the shared time base.
REQ-008 Ports coin_half, coin_one, buy and cancel, input, 1 each: one-cycle debounced key pulses.
REQ-009 Port balance, output, 8: credited amount in 0.5-yuan units.
REQ-010 Port change, output, 8: amount owed back in 0.5-yuan units.
REQ-011 Port vend_out, output, 1: item-release level.
REQ-012 Port change_out, output, 1: coin-return level.
REQ-013 Port reject, output, 1: one-cycle pulse when a coin is refused.
REQ-014 Port busy, output, 1: high while in VEND, CHANGE or REFUND.
REQ-015 Port state, output, 3: current FSM state code for the display driver.

Function
REQ-016 The FSM SHALL have states IDLE=0, PAY=1, VEND=2, CHANGE=3 and REFUND=4; all outputs are registered, with a one-cycle latency from an input pulse.
REQ-017 IDLE/PAY, coin accepted: coin_half adds 1 and coin_one adds 2; both in the same cycle add 3. IDLE moves to PAY on any accepted coin.
REQ-018 Coin refused: if balance plus the coin sum would exceed MAX_BAL, the whole sum is refused; balance is unchanged and reject pulses for 1 cycle.
REQ-019 PAY + buy with balance ≥ PRICE → VEND; change ← balance−PRICE; balance ← 0.
REQ-020 PAY + buy with balance < PRICE: no effect.
REQ-021 PAY + cancel → REFUND; change ← balance; balance ← 0. cancel SHALL take priority over a simultaneous buy.
REQ-022 Coins arriving in the same cycle as an accepted buy or cancel are refused (reject=1).
REQ-023 VEND: vend_out=1; after HOLD_TICKS tick pulses (the tick on the entry cycle is not counted), go to CHANGE if change≠0, else IDLE.
REQ-024 CHANGE and REFUND: change_out=1; after HOLD_TICKS ticks, change ← 0 and go to IDLE.
REQ-025 When busy=1, coins SHALL be refused (reject pulse) and buy/cancel ignored.
REQ-026 Arithmetic SHALL be 8-bit unsigned; the saturation check uses a 9-bit sum, so no wrap-around is possible.
REQ-027 Encodings 5–7 SHALL be unreachable and SHALL recover to IDLE on the next cycle with all outputs cleared.

Reset
REQ-028 On rst=1 at a clk edge, regardless of state: state=IDLE, balance=0, change=0, vend_out=0, change_out=0, reject=0, busy=0, counters=0; any pending credit is discarded.

Configuration
REQ-029 With VEND_TIMEOUT_EN defined: in PAY, an inactivity counter counts ticks, clears on each accepted coin, and at TIMEOUT_TICKS forces REFUND exactly as cancel does.
REQ-030 Without VEND_TIMEOUT_EN: no inactivity counter exists; PAY persists indefinitely, and TIMEOUT_TICKS is unused.

Structure
REQ-031 Package vend_pkg SHALL hold the state encoding constants and the coin value constants (HALF=1, ONE=2).
REQ-032 One sub-module, vend_tick_cnt, SHALL implement the clearable tick counter with a terminal-count flag; it is used for the hold counter and, when enabled, the timeout counter.

Verification
REQ-033 After reset: coin_one, coin_one, coin_half, then buy → balance reads 2, 4, 5; then VEND with change=0; vend_out is high for 4 ticks; then IDLE.
REQ-034 Coins 2+2+2, then buy → change=1; VEND for 4 ticks; CHANGE for 4 ticks; IDLE with change=0.
REQ-035 balance=39, then coin_one → reject pulse and balance stays 39; then coin_half → balance=40.
REQ-036 balance=6, then buy and cancel in the same cycle → REFUND with change=6; a coin in that same cycle is rejected.
REQ-037 rst asserted mid-VEND → next cycle state=0, vend_out=0, balance=0, change=0.
REQ-038 With VEND_TIMEOUT_EN defined, balance=3 and 20 ticks without a coin → REFUND with change=3; without the macro, the state stays PAY.
